scan_seq138: RTL and testbench

Multiplexed-display scan sequencer that sits directly upstream of the 3-to-8 active-low decoder. It cycles a 3-bit channel index with a programmable dwell time and a blanking gap between channels, and drives the decoder's select inputs (A2..A0) and enables (G1, G2, G3). In the same cycle it presents the 4-bit data nibble for the selected channel, taken from a double-buffered 32-bit frame register.

---
 rtl/scan_pkg.sv | 23 ++
 rtl/slot_timer.sv | 34 +++
 rtl/scan_seq138.sv | 195 +++++++++++++++++++
 tb/tb_scan_seq138.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan_seq138 display scan sequencer.
package scan_pkg;

  // Scan FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  // Decoder enable patterns, ordered {G1,G2,G3}.
  localparam logic [2:0] G_ON  = 3'b100;
  localparam logic [2:0] G_OFF = 3'b011;

  // Width of the slot counter: large enough to hold the longer of the two
  // intervals without wrapping.
  function automatic int cnt_width(input int scan_div, input int blank_cyc);
    int longest;
    longest = (scan_div > blank_cyc) ? scan_div : blank_cyc;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Loadable down-counter with terminal-count flag. Loading N-1 on entry to an
// interval makes tc rise in the interval's last cycle, so the interval lasts
// exactly N cycles. The count parks at zero instead of wrapping.
module slot_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  // Counter register: clear has priority over load, load over decrement.
  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/scan_seq138.sv
// Multiplexed-display scan sequencer driving a 3-to-8 active-low decoder.
// The FSM, index and frame buffers form one stage; the decoder-facing
// outputs are registered from that stage, so they trail the FSM by a cycle
// except when en drops, which blanks the outputs on the same edge.
module scan_seq138
  import scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter int NUM_CH    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data_in,
  output logic        A0,
  output logic        A1,
  output logic        A2,
  output logic        G1,
  output logic        G2,
  output logic        G3,
  output logic [3:0]  nibble,
  output logic        frame_start
);

  localparam int             CW         = cnt_width(SCAN_DIV, BLANK_CYC);
  localparam logic [CW-1:0]  ON_LOAD    = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  BLANK_LOAD = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [2:0]     LAST_IDX   = 3'(NUM_CH - 1);
  localparam logic           HAS_BLANK  = (BLANK_CYC > 0);

  // FSM stage
  state_t        state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic          frame_go, frame_go_nxt;  // FSM just entered idx 0
  logic          slot_go, slot_go_nxt;    // FSM just entered a new slot
  logic          commit;                  // frame boundary this cycle

  // Slot timer control
  logic          tmr_clear;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_tc;

  // Frame buffers
  logic [31:0]   pending;
  logic [31:0]   active;
  logic          pend_valid;

  // Output registers
  logic [2:0]    sel;
  logic [2:0]    g;

  slot_timer #(
    .W (CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Next-state logic: interval sequencing, index advance and frame commit.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    frame_go_nxt = 1'b0;
    slot_go_nxt  = 1'b0;
    commit       = 1'b0;
    tmr_clear    = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = ON_LOAD;

    if (!en) begin
      // Abandon any partial slot; a restart always begins a fresh frame.
      state_nxt = IDLE;
      idx_nxt   = 3'd0;
      tmr_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          idx_nxt      = 3'd0;
          commit       = 1'b1;
          frame_go_nxt = 1'b1;
          slot_go_nxt  = 1'b1;
          tmr_load     = 1'b1;
          state_nxt    = HAS_BLANK ? BLANK : ON;
          tmr_val      = HAS_BLANK ? BLANK_LOAD : ON_LOAD;
        end

        BLANK: begin
          if (tmr_tc) begin
            state_nxt = ON;
            tmr_load  = 1'b1;
            tmr_val   = ON_LOAD;
          end
        end

        ON: begin
          if (tmr_tc) begin
            slot_go_nxt = 1'b1;
            tmr_load    = 1'b1;
            state_nxt   = HAS_BLANK ? BLANK : ON;
            tmr_val     = HAS_BLANK ? BLANK_LOAD : ON_LOAD;
            if (idx == LAST_IDX) begin
              idx_nxt      = 3'd0;
              commit       = 1'b1;
              frame_go_nxt = 1'b1;
            end else begin
              idx_nxt = idx + 3'd1;
            end
          end
        end

        default: begin
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
          tmr_clear = 1'b1;
        end
      endcase
    end
  end

  // FSM state, channel index and slot/frame entry pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      frame_go <= 1'b0;
      slot_go  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      frame_go <= frame_go_nxt;
      slot_go  <= slot_go_nxt;
    end
  end

  // Double-buffered frame data: a commit moves the old pending into active
  // while a coincident load still lands in pending and keeps it valid.
  // NOTE: the buffers are reset because a reset must discard queued data;
  // they are plain flops, not a RAM, so this costs nothing structural.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      active     <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (commit && pend_valid) begin
        active <= pending;
      end
      if (load) begin
        pending    <= data_in;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Decoder-facing output registers; A and nibble only move at slot entry,
  // so the selects are stable for the whole time the decoder is enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel         <= 3'd0;
      g           <= G_OFF;
      nibble      <= 4'd0;
      frame_start <= 1'b0;
    end else if (!en) begin
      sel         <= 3'd0;
      g           <= G_OFF;
      frame_start <= 1'b0;
    end else begin
      sel         <= (state == IDLE) ? 3'd0 : idx;
      g           <= (state == ON) ? G_ON : G_OFF;
      frame_start <= frame_go;
      if (slot_go) begin
        nibble <= active[{idx, 2'b00} +: 4];
      end
    end
  end

  assign A0 = sel[0];
  assign A1 = sel[1];
  assign A2 = sel[2];
  assign G1 = g[2];
  assign G2 = g[1];
  assign G3 = g[0];

endmodule

// File: tb/tb_scan_seq138.sv
// Self-checking bench for scan_seq138: SCAN_DIV=4, BLANK_CYC=2, NUM_CH=8 on
// the main instance, and NUM_CH=3, BLANK_CYC=0 on a second instance.
module tb_scan_seq138;
  import scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, load;
  logic [31:0] data_in;
  logic        A0, A1, A2, G1, G2, G3, frame_start;
  logic [3:0]  nibble;

  logic        en_b;
  logic        load_b = 1'b0;
  logic [31:0] data_in_b = 32'h0;
  logic        b_A0, b_A1, b_A2, b_G1, b_G2, b_G3, b_fs;
  logic [3:0]  b_nibble;

  scan_seq138 #(.SCAN_DIV(4), .BLANK_CYC(2), .NUM_CH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data_in),
    .A0(A0), .A1(A1), .A2(A2), .G1(G1), .G2(G2), .G3(G3),
    .nibble(nibble), .frame_start(frame_start)
  );

  scan_seq138 #(.SCAN_DIV(4), .BLANK_CYC(0), .NUM_CH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .load(load_b), .data_in(data_in_b),
    .A0(b_A0), .A1(b_A1), .A2(b_A2), .G1(b_G1), .G2(b_G2), .G3(b_G3),
    .nibble(b_nibble), .frame_start(b_fs)
  );

  always #5 clk = ~clk;

  // Observed output bundle: {A, G, frame_start, nibble}.
  typedef struct packed {
    logic [2:0] a;
    logic [2:0] g;
    logic       fs;
    logic [3:0] nib;
  } obs_t;

  // Explicit timing vectors for the first frame (cycle after en edge).
  typedef struct {
    int         cyc;
    logic [2:0] a;
    logic [2:0] g;
    logic       fs;
  } vec_t;

  vec_t        tbl[10];
  obs_t        sb_q[$];
  logic [31:0] frame_data[0:4];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t obs_main();
    return {A2, A1, A0, G1, G2, G3, frame_start, nibble};
  endfunction

  // Expected main-instance outputs n cycles after the en edge, straight from
  // the slot geometry: 6-cycle slots (2 blank + 4 on), 48-cycle frames.
  function automatic obs_t model(input int n);
    int          p, slot, pos, f;
    logic [31:0] d;
    obs_t        e;
    p    = (n - 1) % 48;
    slot = p / 6;
    pos  = p % 6;
    f    = (n - 1) / 48;
    d    = frame_data[f];
    e.a   = 3'(slot);
    e.g   = (pos >= 2) ? G_ON : G_OFF;
    e.fs  = (p == 0);
    e.nib = d[4*slot +: 4];
    return e;
  endfunction

  initial begin
    obs_t got, exp;

    tbl[0] = '{1,  3'd0, G_OFF, 1'b1};
    tbl[1] = '{2,  3'd0, G_OFF, 1'b0};
    tbl[2] = '{3,  3'd0, G_ON,  1'b0};
    tbl[3] = '{6,  3'd0, G_ON,  1'b0};
    tbl[4] = '{7,  3'd1, G_OFF, 1'b0};
    tbl[5] = '{9,  3'd1, G_ON,  1'b0};
    tbl[6] = '{43, 3'd7, G_OFF, 1'b0};
    tbl[7] = '{48, 3'd7, G_ON,  1'b0};
    tbl[8] = '{49, 3'd0, G_OFF, 1'b1};
    tbl[9] = '{97, 3'd0, G_OFF, 1'b1};

    frame_data[0] = 32'h76543210;
    frame_data[1] = 32'hFFFFFFFF;
    frame_data[2] = 32'h11111111;
    frame_data[3] = 32'hAAAAAAAA;
    frame_data[4] = 32'hAAAAAAAA;

    // Reset state
    rst_n = 1'b0; en = 1'b0; en_b = 1'b0; load = 1'b0; data_in = 32'h0;
    step(); step();
    check("reset_outputs", 32'(obs_main()), 32'({3'd0, G_OFF, 1'b0, 4'd0}));
    check("reset_b_outputs", 32'({b_A2, b_A1, b_A0, b_G1, b_G2, b_G3, b_fs}),
          32'({3'd0, G_OFF, 1'b0}));

    // Load frame 0 while idle, then start scanning.
    rst_n = 1'b1;
    load = 1'b1; data_in = 32'h76543210;
    step();
    load = 1'b0;
    en = 1'b1;
    step();  // en sampled here: cycle 0
    check("en_edge_still_idle", 32'(obs_main()), 32'({3'd0, G_OFF, 1'b0, 4'd0}));

    // Scoreboarded scan over four-plus frames with mid-frame and
    // commit-cycle loads.
    for (int n = 1; n <= 214; n++) begin
      load = (n == 32) || (n == 60) || (n == 96);
      case (n)
        32:      data_in = 32'hFFFFFFFF;  // during idx 5 of frame 0
        60:      data_in = 32'h11111111;
        96:      data_in = 32'hAAAAAAAA;  // exactly on the frame-2 commit edge
        default: data_in = 32'h0;
      endcase
      sb_q.push_back(model(n));
      step();
      got = obs_main();
      exp = sb_q.pop_front();
      check($sformatf("scan_c%0d", n), 32'(got), 32'(exp));
      for (int k = 0; k < 10; k++) begin
        if (tbl[k].cyc == n) begin
          check($sformatf("vec_c%0d", n), 32'({got.a, got.g, got.fs}),
                32'({tbl[k].a, tbl[k].g, tbl[k].fs}));
        end
      end
    end
    load = 1'b0; data_in = 32'h0;

    // en=0 while ON at idx 3: blank immediately, then restart at idx 0.
    check("pre_stop_on_idx3", 32'({A2, A1, A0, G1, G2, G3}), 32'({3'd3, G_ON}));
    en = 1'b0;
    step();
    check("stop_blanks", 32'({A2, A1, A0, G1, G2, G3, frame_start}), 32'({3'd0, G_OFF, 1'b0}));
    step();
    check("stop_stays_idle", 32'({A2, A1, A0, G1, G2, G3, frame_start}), 32'({3'd0, G_OFF, 1'b0}));
    en = 1'b1;
    step();
    check("restart_edge_idle", 32'(frame_start), 32'(1'b0));
    step();
    check("restart_frame_start", 32'(obs_main()), 32'({3'd0, G_OFF, 1'b1, 4'hA}));
    step();
    check("restart_fs_single", 32'(frame_start), 32'(1'b0));
    step();
    check("restart_on_c3", 32'({A2, A1, A0, G1, G2, G3}), 32'({3'd0, G_ON}));

    // Three channels, no blanking: 4 cycles per channel, G never drops.
    en_b = 1'b1;
    step();
    for (int m = 1; m <= 26; m++) begin
      step();
      check($sformatf("noblank_c%0d", m),
            32'({b_A2, b_A1, b_A0, b_G1, b_G2, b_G3, b_fs}),
            32'({3'(((m - 1) / 4) % 3), G_ON, 1'(((m - 1) % 12) == 0)}));
    end

    // Reset mid-frame discards both buffers.
    rst_n = 1'b0;
    step();
    check("midreset_outputs", 32'(obs_main()), 32'({3'd0, G_OFF, 1'b0, 4'd0}));
    rst_n = 1'b1;
    step();
    step();
    check("post_reset_frame", 32'(obs_main()), 32'({3'd0, G_OFF, 1'b1, 4'd0}));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
